// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready are high.
// Operand side: in_valid/in_ready. in_ready is high only in IDLE and only while rst is low.
// Result side: out_valid/out_ready. out_valid stays high, and diff/bout/ovf stay stable,
// until out_ready is seen.
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers. diff_sh collects the low WIDTH-1 result bits. The last bit
  // is merged in on the final edge, so diff itself only changes when a result completes.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] diff_sh;
  logic             a_msb;
  logic             b_msb;
  logic             borrow;
  logic [CW-1:0]    count;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] diff_cat;

  assign ai       = a_sh[0];
  assign bi       = b_sh[0];
  assign d        = ai ^ bi ^ borrow;
  assign br_next  = (~ai & bi) | (~(ai ^ bi) & borrow);
  assign last_bit = (count == CW'(WIDTH - 1));
  assign diff_cat = {d, diff_sh};

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state == SHIFT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: accept, shift WIDTH bits, then hold until the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, ripple one borrow per edge, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      diff_sh   <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      borrow    <= 1'b0;
      count     <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            borrow <= bin;
            count  <= '0;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          diff_sh <= diff_cat[WIDTH-1:1];
          borrow  <= br_next;
          count   <= count + CW'(1);
          if (last_bit) begin
            diff      <= diff_cat;
            bout      <= br_next;
            ovf       <= (a_msb != b_msb) && (d != a_msb);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=3 cases plus random back-to-back WIDTH=8 traffic.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  // WIDTH = 3 instance
  logic       in_valid3, in_ready3, bin3, out_valid3, out_ready3, bout3, ovf3, busy3;
  logic [2:0] a3, b3, diff3;

  // WIDTH = 8 instance
  logic       in_valid8, in_ready8, bin8, out_valid8, out_ready8, bout8, ovf8, busy8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  bit          mon8 = 0;
  logic        ov8_prev = 0;
  int          last_rise = -1;
  int          rises = 0;

  localparam int N8 = 30;

  serial_subtractor #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .bin(bin3), .out_valid(out_valid3), .out_ready(out_ready3),
    .diff(diff3), .bout(bout3), .ovf(ovf3), .busy(busy3)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .ovf(ovf8), .busy(busy8)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Packed as {ovf, bout, diff[w-1:0]}.
  function automatic logic [31:0] model(input int w, input int a, input int b, input int bi);
    int mask, d, bo, am, bm, dm, ov;
    mask = (1 << w) - 1;
    d    = (a - b - bi) & mask;
    bo   = (a < (b + bi)) ? 1 : 0;
    am   = (a >> (w - 1)) & 1;
    bm   = (b >> (w - 1)) & 1;
    dm   = (d >> (w - 1)) & 1;
    ov   = ((am != bm) && (dm != am)) ? 1 : 0;
    return 32'((ov << (w + 1)) | (bo << w) | d);
  endfunction

  // Drive one WIDTH=3 operation, check latency and result against literals and the model.
  task automatic run3(input string name, input logic [2:0] a, input logic [2:0] b, input logic bi,
                      input logic [2:0] ed, input logic eb, input logic eo);
    int lat;
    logic [31:0] m;
    m = model(3, int'(a), int'(b), int'(bi));
    @(posedge clk); #1;
    a3 = a; b3 = b; bin3 = bi; in_valid3 = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready3), 32'd1);
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
    lat = 0;
    @(negedge clk);
    check({name, "_busy"}, 32'(busy3), 32'd1);
    while (!out_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_diff"}, 32'(diff3), 32'(ed));
    check({name, "_bout"}, 32'(bout3), 32'(eb));
    check({name, "_ovf"}, 32'(ovf3), 32'(eo));
    check({name, "_model"}, 32'({ovf3, bout3, diff3}), m);
    if (out_ready3) begin
      @(negedge clk);
      check({name, "_ov_clear"}, 32'(out_valid3), 32'd0);
      check({name, "_idle"}, 32'(in_ready3), 32'd1);
    end
  endtask

  // Compare process for the WIDTH=8 instance: every result and its spacing.
  always @(negedge clk) begin
    logic [31:0] e;
    if (mon8 && !rst) begin
      if (out_valid8) check("w8_busy_excl", 32'(busy8), 32'd0);
      if (out_valid8 && !ov8_prev) begin
        rises++;
        if (last_rise >= 0) check("w8_spacing", 32'(cyc - last_rise), 32'd10);
        last_rise = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w8_unexpected actual=%0h expected=none", {ovf8, bout8, diff8});
        end else begin
          e = exp_q.pop_front();
          check("w8_result", 32'({ovf8, bout8, diff8}), e);
        end
      end
      ov8_prev = out_valid8;
    end
  end

  // Main sequence
  initial begin
    logic [9:0]  held;
    logic [7:0]  ca[5];
    logic [7:0]  cb[5];
    logic        cbi[5];
    int          accepted, guard, k;

    rst = 1'b1;
    in_valid3 = 0; a3 = 0; b3 = 0; bin3 = 0; out_ready3 = 1;
    in_valid8 = 0; a8 = 0; b8 = 0; bin8 = 0; out_ready8 = 1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready3), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid3), 32'd0);
    check("rst_diff", 32'(diff3), 32'd0);
    check("rst_bout_ovf", 32'({bout3, ovf3}), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_in_ready", 32'(in_ready3), 32'd1);

    // Directed WIDTH=3 cases (-3 - 3 = -6 does not fit in 3 bits, so ovf=1)
    run3("t1", 3'b101, 3'b011, 1'b0, 3'b010, 1'b0, 1'b1);
    run3("t2", 3'b011, 3'b101, 1'b0, 3'b110, 1'b1, 1'b1);
    run3("t3", 3'b000, 3'b000, 1'b1, 3'b111, 1'b1, 1'b0);

    // Backpressure: result held for 5 cycles, in_valid ignored
    out_ready3 = 1'b0;
    run3("t4", 3'b110, 3'b011, 1'b0, 3'b011, 1'b0, 1'b1);
    held = {ovf3, bout3, diff3, 3'b000};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid3 = 1'b1; a3 = 3'($urandom); b3 = 3'($urandom); bin3 = 1'($urandom);
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid3), 32'd1);
      check("t4_hold_result", 32'({ovf3, bout3, diff3, 3'b000}), 32'(held));
      check("t4_in_ready_low", 32'(in_ready3), 32'd0);
    end
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    out_ready3 = 1'b1;
    @(negedge clk);
    check("t4_valid_before_hs", 32'(out_valid3), 32'd1);
    @(negedge clk);
    check("t4_after_hs_valid", 32'(out_valid3), 32'd0);
    check("t4_after_hs_ready", 32'(in_ready3), 32'd1);
    check("t4_retained", 32'({ovf3, bout3, diff3, 3'b000}), 32'(held));

    // Reset in the middle of SHIFT
    @(posedge clk); #1;
    a3 = 3'b010; b3 = 3'b001; bin3 = 1'b0; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy_mid", 32'(busy3), 32'd1);
    check("t5_in_ready_rst", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_idle", 32'(busy3), 32'd0);
    check("t5_out_valid", 32'(out_valid3), 32'd0);
    check("t5_diff", 32'(diff3), 32'd0);
    check("t5_in_ready", 32'(in_ready3), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("t5_no_partial", 32'(out_valid3), 32'd0);
    end
    run3("t5_fresh", 3'b111, 3'b001, 1'b0, 3'b110, 1'b0, 1'b0);

    // Random back-to-back WIDTH=8 traffic, corners first
    ca[0] = 8'h00; cb[0] = 8'h00; cbi[0] = 1'b1;
    ca[1] = 8'hff; cb[1] = 8'h00; cbi[1] = 1'b0;
    ca[2] = 8'h00; cb[2] = 8'hff; cbi[2] = 1'b1;
    ca[3] = 8'h80; cb[3] = 8'h01; cbi[3] = 1'b0;
    ca[4] = 8'h7f; cb[4] = 8'hff; cbi[4] = 1'b0;
    mon8 = 1;
    accepted = 0;
    guard = 0;
    @(posedge clk); #1;
    a8 = ca[0]; b8 = cb[0]; bin8 = cbi[0]; in_valid8 = 1'b1;
    while (accepted < N8 && guard < 2000) begin
      k = accepted;
      @(negedge clk);
      if (in_ready8) begin
        exp_q.push_back(model(8, int'(a8), int'(b8), int'(bin8)));
        accepted++;
      end
      @(posedge clk); #1;
      if (accepted != k) begin
        if (accepted >= N8) begin
          in_valid8 = 1'b0;
        end else if (accepted < 5) begin
          a8 = ca[accepted]; b8 = cb[accepted]; bin8 = cbi[accepted];
        end else begin
          a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
          bin8 = 1'($urandom_range(0, 1));
        end
      end
      guard++;
    end
    check("w8_accepted", 32'(accepted), 32'(N8));
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("w8_drain", 32'(exp_q.size()), 32'd0);
    check("w8_rises", 32'(rises), 32'(N8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
